// File: rtl/ring_sequencer_pkg.sv
// Shared types and helpers for the ring sequencer and its dwell counter.
package ring_seq_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Width of a state index for an n-entry ring; at least one bit.
  function automatic int state_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ring_sequencer_dwell_counter.sv
// Per-state dwell counter: tick fires on the enabled cycle where the count reaches limit.
module dwell_counter #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [DWELL_W-1:0] limit,
  output logic               tick
);

  logic [DWELL_W-1:0] count_q;

  assign tick = en && (count_q == limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr || tick) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/ring_sequencer.sv
// Parametrised cyclic state sequencer with direction, dwell, load, wrap pulse and error flag.
module ring_sequencer
  import ring_seq_pkg::*;
#(
  parameter  int NUM_STATES = 3,
  parameter  int DWELL_W    = 4,
  localparam int SW         = state_w(NUM_STATES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               dir,
  input  logic [SW-1:0]      cfg_last,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               load,
  input  logic [SW-1:0]      load_val,
  output logic [SW-1:0]      state_o,
  output logic [SW-1:0]      next_o,
  output logic [SW-1:0]      out_o,
  output logic               wrap_o,
  output logic               err_o
);

  localparam logic [SW-1:0] MAX_IDX = SW'(NUM_STATES - 1);
  localparam logic [SW:0]   NUM_EXT = (SW+1)'(NUM_STATES);

  logic [SW-1:0] state_q, state_d, last, next_state;
  logic          wrap_q, wrap_d, err_q, err_d;
  logic          tick, bad_enc, over_last;

  dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (load),
    .limit (dwell),
    .tick  (tick)
  );

  // Anything past the active ring (including unused encodings) recovers to 0.
  always_comb begin
    last       = (cfg_last > MAX_IDX) ? MAX_IDX : cfg_last;
    bad_enc    = ({1'b0, state_q} >= NUM_EXT);
    over_last  = (state_q > last);
    next_state = '0;
    if (!over_last) begin
      case (dir_e'(dir))
        DIR_UP:   next_state = (state_q == last) ? '0 : state_q + 1'b1;
        DIR_DOWN: next_state = (state_q == '0) ? last : state_q - 1'b1;
        default:  next_state = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    err_d   = err_q | bad_enc;
    if (load) begin
      if (load_val > last) begin
        state_d = '0;
        err_d   = 1'b1;
      end else begin
        state_d = load_val;
      end
    end else if (tick) begin
      state_d = next_state;
      wrap_d  = !over_last &&
                (((dir_e'(dir) == DIR_UP)   && (state_q == last)) ||
                 ((dir_e'(dir) == DIR_DOWN) && (state_q == '0)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign state_o = state_q;
  assign next_o  = next_state;
  assign out_o   = state_q | next_state;
  assign wrap_o  = wrap_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_ring_sequencer.sv
// Directed vector bench for ring_sequencer (3-state instance plus a 4-state instance for load range).
module tb_ring_sequencer;

  typedef struct {
    logic       rst;
    logic       en;
    logic       dir;
    logic [1:0] cfg;
    logic [3:0] dw;
    logic       ld;
    logic [1:0] lv;
    logic [1:0] e_state;
    logic [1:0] e_next;
    logic [1:0] e_out;
    logic       e_wrap;
    logic       e_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic [1:0] cfg_last = 2'd2;
  logic [3:0] dwell = 4'd0;
  logic       load = 1'b0;
  logic [1:0] load_val = 2'd0;

  logic [1:0] state_o, next_o, out_o;
  logic       wrap_o, err_o;
  logic [1:0] state4, next4, out4;
  logic       wrap4, err4;

  int compared = 0;
  int mismatched = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  ring_sequencer #(.NUM_STATES(3), .DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .cfg_last(cfg_last), .dwell(dwell),
    .load(load), .load_val(load_val), .state_o(state_o), .next_o(next_o),
    .out_o(out_o), .wrap_o(wrap_o), .err_o(err_o)
  );

  ring_sequencer #(.NUM_STATES(4), .DWELL_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .cfg_last(cfg_last), .dwell(dwell),
    .load(load), .load_val(load_val), .state_o(state4), .next_o(next4),
    .out_o(out4), .wrap_o(wrap4), .err_o(err4)
  );

  function automatic vec_t mk(input logic r, input logic e, input logic d, input logic [1:0] c,
                              input logic [3:0] w, input logic l, input logic [1:0] v,
                              input logic [1:0] s, input logic [1:0] n, input logic [1:0] o,
                              input logic wr, input logic er);
    vec_t t;
    t.rst = r; t.en = e; t.dir = d; t.cfg = c; t.dw = w; t.ld = l; t.lv = v;
    t.e_state = s; t.e_next = n; t.e_out = o; t.e_wrap = wr; t.e_err = er;
    return t;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst = v.rst; en = v.en; dir = v.dir; cfg_last = v.cfg;
    dwell = v.dw; load = v.ld; load_val = v.lv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [3:0] act,
                             input logic [3:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic d, input logic [1:0] c,
                      input logic [3:0] w, input logic l, input logic [1:0] v);
    applyStimulus(mk(r, e, d, c, w, l, v, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
  endtask

  initial begin
    //         rst en dir cfg dw ld lv   state next out wrap err
    vecs.push_back(mk(1, 0, 0, 2, 0, 0, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 0, 0, 0,  1, 2, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 0, 0, 0,  2, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 0, 0, 0,  0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2, 0, 0, 0,  1, 2, 3, 0, 0));
    vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0,  0, 2, 2, 0, 0));
    vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0,  2, 1, 3, 1, 0));
    vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0,  1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0,  0, 2, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 2, 0, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 2, 0, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 2, 0, 0,  1, 2, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 2, 0, 0,  1, 2, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 2, 0, 0,  1, 2, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 2, 0, 0,  2, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 1, 0, 0,  2, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 2, 1, 0, 0,  2, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 2, 1, 0, 0,  2, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 1, 0, 0,  0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2, 1, 1, 1,  1, 2, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 1, 0, 0,  1, 2, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 1, 0, 0,  2, 0, 2, 0, 0));
    // cfg_last shrunk below the current state: recover to 0 whatever dir says
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0,  2, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0,  2, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 1, 1, 3,  0, 1, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 3, 0, 0, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 3, 0, 0, 0,  1, 2, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 3, 0, 0, 0,  2, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 3, 0, 0, 0,  0, 1, 1, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput("state", i, {2'b0, state_o}, {2'b0, vecs[i].e_state});
      checkOutput("next",  i, {2'b0, next_o},  {2'b0, vecs[i].e_next});
      checkOutput("out",   i, {2'b0, out_o},   {2'b0, vecs[i].e_out});
      checkOutput("wrap",  i, {3'b0, wrap_o},  {3'b0, vecs[i].e_wrap});
      checkOutput("err",   i, {3'b0, err_o},   {3'b0, vecs[i].e_err});
    end

    // Reset in the middle of a dwell must drop the partial count and the sticky error
    step(0, 1, 0, 2, 0, 1, 3);
    checkOutput("mid_err_set", 100, {3'b0, err_o}, 4'd1);
    step(0, 1, 0, 2, 0, 0, 0);
    checkOutput("mid_pre_state", 101, {2'b0, state_o}, 4'd1);
    step(0, 1, 0, 2, 2, 0, 0);
    checkOutput("mid_hold", 102, {2'b0, state_o}, 4'd1);
    step(1, 1, 0, 2, 2, 0, 0);
    checkOutput("mid_rst_state", 103, {2'b0, state_o}, 4'd0);
    checkOutput("mid_rst_wrap",  103, {3'b0, wrap_o}, 4'd0);
    checkOutput("mid_rst_err",   103, {3'b0, err_o}, 4'd0);
    step(0, 1, 0, 2, 1, 0, 0);
    checkOutput("mid_cnt_zero", 104, {2'b0, state_o}, 4'd0);
    step(0, 1, 0, 2, 1, 0, 0);
    checkOutput("mid_adv", 105, {2'b0, state_o}, 4'd1);

    // Four-entry ring with cfg_last=2: load of 3 is out of range
    step(1, 0, 0, 2, 0, 0, 0);
    step(0, 0, 0, 2, 0, 1, 3);
    checkOutput("n4_bad_state", 110, {2'b0, state4}, 4'd0);
    checkOutput("n4_bad_err",   110, {3'b0, err4}, 4'd1);
    checkOutput("n4_bad_wrap",  110, {3'b0, wrap4}, 4'd0);
    step(0, 1, 0, 2, 0, 0, 0);
    step(0, 1, 0, 2, 0, 0, 0);
    checkOutput("n4_run_state", 111, {2'b0, state4}, 4'd2);
    checkOutput("n4_sticky",    111, {3'b0, err4}, 4'd1);
    step(1, 0, 0, 2, 0, 0, 0);
    checkOutput("n4_rst_err", 112, {3'b0, err4}, 4'd0);
    step(0, 0, 0, 3, 0, 1, 3);
    checkOutput("n4_ok_state", 113, {2'b0, state4}, 4'd3);
    checkOutput("n4_ok_err",   113, {3'b0, err4}, 4'd0);

    // Unreachable encoding in the 3-entry ring
    step(1, 0, 0, 2, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; dir = 1'b0; cfg_last = 2'd2; dwell = 4'd0; load = 1'b0;
    force dut.state_q = 2'd3;
    #1;
    checkOutput("bad_next", 120, {2'b0, next_o}, 4'd0);
    checkOutput("bad_err_pre", 120, {3'b0, err_o}, 4'd0);
    release dut.state_q;
    @(posedge clk);
    #1;
    checkOutput("bad_recover", 121, {2'b0, state_o}, 4'd0);
    checkOutput("bad_err", 121, {3'b0, err_o}, 4'd1);
    checkOutput("bad_wrap", 121, {3'b0, wrap_o}, 4'd0);
    step(0, 1, 0, 2, 0, 0, 0);
    checkOutput("bad_after", 122, {2'b0, state_o}, 4'd1);
    checkOutput("bad_sticky", 122, {3'b0, err_o}, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
